// File: rtl/key_expansion_gen.sv
// key_expansion_gen: word-serial AES key expansion (AES-128/192/256).
// Streams w[0]..w[Total-1] over a valid/ready port. SubWord is computed by a
// shared external 4-lane S-box with a fixed latency of SB_LAT cycles.
//
// Handshake rules, for both key_valid/key_ready and rk_valid/rk_ready:
// a word transfers on a rising edge where valid and ready are both high.
// The producer holds its word stable while valid is high and ready is low.
// key_ready and rk_valid depend only on registered state.
module key_expansion_gen #(
  parameter int SB_LAT = 1,
  parameter bit EN_256 = 1'b1,
  parameter int IDX_W  = 6
) (
  input  logic             gated_clk_ff,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [31:0]      key_word,
  output logic             sb_req,
  output logic [31:0]      sb_in,
  input  logic [31:0]      sb_out,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [31:0]      rk_word,
  output logic [IDX_W-1:0] rk_index,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  // Sliding window of the most recent words; win_q[0] is the newest, w[i-1].
  localparam int WIN = EN_256 ? 8 : 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_GEN     = 3'd2,
    S_SB_WAIT = 3'd3,
    S_EMIT    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      win_q [WIN];
  logic [IDX_W-1:0] index_q, index_d;
  logic [3:0]       mod_q, mod_d;     // index mod Nk, kept as a wrapping counter
  logic [3:0]       nk_q, nk_d;
  logic [IDX_W-1:0] total_q, total_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [2:0]       cnt_q, cnt_d;     // S-box wait counter
  logic             rot_q, rot_d;     // pending SubWord is the RotWord+Rcon case
  logic             done_q, done_d;

  logic             shift_en;
  logic [31:0]      new_word;
  logic [3:0]       nk_sel;
  logic [IDX_W-1:0] total_sel;
  logic [31:0]      temp_word;
  logic [31:0]      rot_word;
  logic [31:0]      far_word;
  logic [7:0]       rcon_next;
  logic             need_rot;
  logic             need_sub;
  logic             last_idx;
  logic             key_phase;

  // Decode key length into Nk and word total; unsupported codes fall back to AES-128.
  always_comb begin
    nk_sel    = 4'd4;
    total_sel = IDX_W'(44);
    case (key_len)
      2'd1: begin
        nk_sel    = 4'd6;
        total_sel = IDX_W'(52);
      end
      2'd2: begin
        if (EN_256) begin
          nk_sel    = 4'd8;
          total_sel = IDX_W'(60);
        end
      end
      default: ;
    endcase
  end

  // Select w[i-Nk] from the window without a variable-width index.
  always_comb begin
    far_word = win_q[0];
    for (int k = 0; k < WIN; k++) begin
      if (4'(k) == nk_q - 4'd1) far_word = win_q[k];
    end
  end

  assign temp_word = win_q[0];
  assign rot_word  = {temp_word[23:0], temp_word[31:24]};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  assign need_rot  = (mod_q == 4'd0);
  assign need_sub  = need_rot || ((nk_q == 4'd8) && (mod_q == 4'd4));
  assign last_idx  = (index_q == total_q - IDX_W'(1));
  assign key_phase = (index_q < IDX_W'(nk_q) - IDX_W'(1));

  // Next-state and output decode for the expansion FSM.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    mod_d     = mod_q;
    nk_d      = nk_q;
    total_d   = total_q;
    rcon_d    = rcon_q;
    cnt_d     = cnt_q;
    rot_d     = rot_q;
    done_d    = 1'b0;
    shift_en  = 1'b0;
    new_word  = 32'h0;
    key_ready = 1'b0;
    sb_req    = 1'b0;
    sb_in     = 32'h0;
    rk_valid  = 1'b0;
    rk_word   = 32'h0;
    rk_index  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nk_d    = nk_sel;
          total_d = total_sel;
          index_d = '0;
          mod_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        key_ready = 1'b1;
        if (key_valid) begin
          shift_en = 1'b1;
          new_word = key_word;
          state_d  = S_EMIT;
        end
      end
      S_EMIT: begin
        rk_valid = 1'b1;
        rk_word  = win_q[0];
        rk_index = index_q;
        if (rk_ready) begin
          index_d = index_q + IDX_W'(1);
          mod_d   = (mod_q == nk_q - 4'd1) ? 4'd0 : mod_q + 4'd1;
          if (last_idx) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (key_phase) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_GEN;
          end
        end
      end
      S_GEN: begin
        if (need_sub) begin
          sb_req  = 1'b1;
          sb_in   = need_rot ? rot_word : temp_word;
          rot_d   = need_rot;
          cnt_d   = 3'd1;
          state_d = S_SB_WAIT;
        end else begin
          shift_en = 1'b1;
          new_word = far_word ^ temp_word;
          state_d  = S_EMIT;
        end
      end
      S_SB_WAIT: begin
        // Window is frozen here, so sb_in stays equal to the requested value.
        sb_in = rot_q ? rot_word : temp_word;
        if (cnt_q == 3'(SB_LAT)) begin
          shift_en = 1'b1;
          new_word = far_word ^ sb_out ^ (rot_q ? {rcon_q, 24'h0} : 32'h0);
          if (rot_q) rcon_d = rcon_next;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and bookkeeping registers.
  always_ff @(posedge gated_clk_ff) begin
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      mod_q   <= 4'd0;
      nk_q    <= 4'd4;
      total_q <= IDX_W'(44);
      rcon_q  <= 8'h01;
      cnt_q   <= 3'd0;
      rot_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      mod_q   <= mod_d;
      nk_q    <= nk_d;
      total_q <= total_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      done_q  <= done_d;
    end
  end

  // Word window: every new key or generated word shifts in at position 0.
  always_ff @(posedge gated_clk_ff) begin
    if (rst) begin
      for (int k = 0; k < WIN; k++) win_q[k] <= 32'h0;
    end else if (shift_en) begin
      win_q[0] <= new_word;
      for (int k = 1; k < WIN; k++) win_q[k] <= win_q[k-1];
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_key_expansion_gen.sv
// Bench for key_expansion_gen: S-box model with latency, scoreboard queue of
// expected {index, word} pairs, directed AES key vectors.
module tb_key_expansion_gen;

  localparam int SB_LAT = 3;
  localparam int IDX_W  = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       key_len;
  logic             key_valid;
  logic             key_ready;
  logic [31:0]      key_word;
  logic             sb_req;
  logic [31:0]      sb_in;
  logic [31:0]      sb_out;
  logic             rk_valid;
  logic             rk_ready;
  logic [31:0]      rk_word;
  logic [IDX_W-1:0] rk_index;
  logic             busy;
  logic             done;
  logic [2:0]       dbg_state;

  // Clock / reset block
  always #5 clk = ~clk;

  key_expansion_gen #(.SB_LAT(SB_LAT), .EN_256(1'b1), .IDX_W(IDX_W)) dut (
    .gated_clk_ff(clk),
    .rst(rst),
    .start(start),
    .key_len(key_len),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_word(key_word),
    .sb_req(sb_req),
    .sb_in(sb_in),
    .sb_out(sb_out),
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .rk_word(rk_word),
    .rk_index(rk_index),
    .busy(busy),
    .done(done),
    .dbg_state(dbg_state)
  );

  logic [7:0]       sbox_t [0:255];
  logic [7:0]       rcon_t [0:9];
  logic [31:0]      key_w  [0:7];
  logic [31:0]      got_w  [0:63];
  logic [IDX_W+31:0] exp_q [$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  words_seen, sb_cnt, done_cnt, start_cyc, done_cyc;
  bit  stall_mode = 1'b0;
  bit  prev_stall = 1'b0;
  logic [IDX_W-1:0] prev_idx;
  logic [31:0]      prev_word;

  logic [SB_LAT-1:0] sb_vld = '0;
  logic [31:0]       sb_dat [SB_LAT];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // External S-box: result valid exactly SB_LAT cycles after the request,
  // garbage otherwise so a mistimed capture is visible.
  always @(posedge clk) begin
    sb_vld[0] <= sb_req;
    sb_dat[0] <= subw(sb_in);
    for (int k = 1; k < SB_LAT; k++) begin
      sb_vld[k] <= sb_vld[k-1];
      sb_dat[k] <= sb_dat[k-1];
    end
  end
  assign sb_out = sb_vld[SB_LAT-1] ? sb_dat[SB_LAT-1] : 32'hdeadbeef;

  // Consumer ready driver
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor / scoreboard: sampled mid-cycle, transfer happens at the next edge
  always @(negedge clk) begin
    if (!rst) begin
      if (sb_req) begin
        sb_cnt++;
        check("sb_overlap", 64'(|sb_vld), 64'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start && !busy) start_cyc = cyc;
      if (prev_stall)
        check("rk_hold", 64'({rk_valid, rk_index, rk_word}), 64'({1'b1, prev_idx, prev_word}));
      prev_stall = rk_valid && !rk_ready;
      prev_idx   = rk_index;
      prev_word  = rk_word;
      if (rk_valid && rk_ready) begin
        words_seen++;
        got_w[rk_index] = rk_word;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rk_unexpected: actual idx %0d word %h required none", rk_index, rk_word);
        end else begin
          check("rk_word", 64'({rk_index, rk_word}), 64'(exp_q.pop_front()));
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, 64'({key_ready, sb_req, rk_valid, busy, done}), 64'd0);
    check({tag, "_sb_in"}, 64'(sb_in), 64'd0);
    check({tag, "_rk_word"}, 64'(rk_word), 64'd0);
    check({tag, "_rk_index"}, 64'(rk_index), 64'd0);
  endtask

  // Driver: model the schedule, queue expectations, start, feed the key, wait.
  task automatic run_aes(input string tag, input logic [1:0] kl, input int nk, input bit stall,
                         input bit poke, input int abort_at, input int exp_sb);
    int          total, last, budget, k, lat;
    bit          acc, hit;
    logic [31:0] w [0:63];
    logic [31:0] t;
    logic [IDX_W-1:0] ix;
    total = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = key_w[i];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    last = (abort_at >= 0) ? abort_at : total - 1;
    for (int i = 0; i <= last; i++) begin
      ix = i[IDX_W-1:0];
      exp_q.push_back({ix, w[i]});
    end
    for (int i = 0; i < 64; i++) got_w[i] = 32'h0;
    words_seen = 0;
    sb_cnt     = 0;
    done_cnt   = 0;
    stall_mode = stall;
    key_len = kl;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    budget = 0;
    while (k < nk && budget < 2000) begin
      key_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      key_word  = key_w[k];
      @(negedge clk);
      acc = key_valid && key_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      budget++;
    end
    key_valid = 1'b0;
    if (k < nk) fail_now({tag, "_key_load"});
    if (poke) begin
      repeat (6) @(posedge clk);
      #1;
      start   = 1'b1;
      key_len = 2'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (abort_at >= 0) begin
      budget = 0;
      hit = 1'b0;
      while (!hit && budget < 5000) begin
        @(negedge clk);
        hit = rk_valid && rk_ready && (rk_index == abort_at[IDX_W-1:0]);
        budget++;
      end
      if (!hit) fail_now({tag, "_abort_wait"});
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_idle({tag, "_abort"});
      @(posedge clk);
      #1;
      rst = 1'b0;
      check({tag, "_flush"}, 64'(exp_q.size()), 64'd0);
    end else begin
      budget = 0;
      while (done_cnt == 0 && budget < 5000) begin
        @(posedge clk);
        budget++;
      end
      repeat (3) @(posedge clk);
      #1;
      if (done_cnt == 0) fail_now({tag, "_done_wait"});
      check({tag, "_words"}, 64'(words_seen), 64'(total));
      check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check({tag, "_sb_req_cnt"}, 64'(sb_cnt), 64'(exp_sb));
      check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
      if (!stall) begin
        lat = 2 * nk + 2 * (total - nk - exp_sb) + (SB_LAT + 2) * exp_sb + 1;
        check({tag, "_latency"}, 64'(done_cyc - start_cyc), 64'(lat));
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
    end
    exp_q.delete();
    stall_mode = 1'b0;
    key_len    = 2'd0;
  endtask

  task automatic set_key128();
    key_w[0] = 32'h2b7e1516; key_w[1] = 32'h28aed2a6;
    key_w[2] = 32'habf71588; key_w[3] = 32'h09cf4f3c;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Main stimulus
  initial begin
    sbox_t = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    rcon_t = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};
    for (int i = 0; i < 8; i++) key_w[i] = 32'h0;
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key_valid = 1'b0; key_word = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // AES-128, no stalls
    set_key128();
    run_aes("aes128", 2'd0, 4, 1'b0, 1'b0, -1, 10);
    check("aes128_w0", 64'(got_w[0]), 64'h2b7e1516);
    check("aes128_w3", 64'(got_w[3]), 64'h09cf4f3c);
    check("aes128_w4", 64'(got_w[4]), 64'ha0fafe17);
    check("aes128_w43", 64'(got_w[43]), 64'hb6630ca6);

    // AES-192
    key_w[0] = 32'h8e73b0f7; key_w[1] = 32'hda0e6452; key_w[2] = 32'hc810f32b;
    key_w[3] = 32'h809079e5; key_w[4] = 32'h62f8ead2; key_w[5] = 32'h522c6b7b;
    run_aes("aes192", 2'd1, 6, 1'b0, 1'b0, -1, 8);
    check("aes192_w6", 64'(got_w[6]), 64'hfe0c91f7);
    check("aes192_w51", 64'(got_w[51]), 64'h01002202);

    // AES-256
    key_w[0] = 32'h603deb10; key_w[1] = 32'h15ca71be; key_w[2] = 32'h2b73aef0;
    key_w[3] = 32'h857d7781; key_w[4] = 32'h1f352c07; key_w[5] = 32'h3b6108d7;
    key_w[6] = 32'h2d9810a3; key_w[7] = 32'h0914dff4;
    run_aes("aes256", 2'd2, 8, 1'b0, 1'b0, -1, 13);
    check("aes256_w8", 64'(got_w[8]), 64'h9ba35411);
    check("aes256_w12", 64'(got_w[12]), 64'ha8b09c1a);
    check("aes256_w59", 64'(got_w[59]), 64'h706c631e);

    // AES-256 with a stray start and a key_len change mid-run
    run_aes("aes256_poke", 2'd2, 8, 1'b0, 1'b1, -1, 13);
    check("poke_w59", 64'(got_w[59]), 64'h706c631e);

    // AES-128 with random key and round-key stalls
    set_key128();
    run_aes("aes128_stall", 2'd0, 4, 1'b1, 1'b0, -1, 10);
    check("stall_w43", 64'(got_w[43]), 64'hb6630ca6);

    // Abort at index 20, then restart with key_len=3
    run_aes("abort", 2'd0, 4, 1'b0, 1'b0, 20, 10);
    repeat (2) @(posedge clk);
    #1;
    run_aes("restart", 2'd3, 4, 1'b0, 1'b0, -1, 10);
    check("restart_w4", 64'(got_w[4]), 64'ha0fafe17);
    check("restart_w43", 64'(got_w[43]), 64'hb6630ca6);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
